// File: rtl/i2s_receive.sv
// I2S serial receiver: oversamples sck/ws/sd in the clk domain, deserialises
// MSB-first slots and publishes left-justified left/right words with 1-clk strobes.
module i2s_receive #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  ws,
    input  logic                  sd,
    output logic [DATA_WIDTH-1:0] data_left,
    output logic [DATA_WIDTH-1:0] data_right,
    output logic                  left_valid,
    output logic                  right_valid,
    output logic                  frame_valid,
    output logic                  locked
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ws_sync_q,  ws_sync_d;
    logic [SYNC_STAGES-1:0] sd_sync_q,  sd_sync_d;
    logic                   sck_d_q, sck_d_d;
    logic                   ws_d_q, ws_d_d;
    logic [0:0]             state_q, state_d;
    logic                   chan_q, chan_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  sreg_q, sreg_d;
    logic [DATA_WIDTH-1:0]  data_left_q, data_left_d;
    logic [DATA_WIDTH-1:0]  data_right_q, data_right_d;
    logic                   left_valid_q, left_valid_d;
    logic                   right_valid_q, right_valid_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   got_left_q, got_left_d;
    logic                   locked_q, locked_d;

    logic                   sck_s, ws_s, sd_s;
    logic                   sck_rise, ws_edge, cnt_full;
    logic [DATA_WIDTH-1:0]  sreg_ins;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ws_s     = ws_sync_q[SYNC_STAGES-1];
    assign sd_s     = sd_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d_q;
    assign ws_edge  = ws_s != ws_d_q;
    assign cnt_full = bit_cnt_q >= CNT_W'(DATA_WIDTH);

    // Shift register with the current sd bit placed at its MSB-first position.
    always_comb begin
        sreg_ins = sreg_q;
        if (!cnt_full) begin
            sreg_ins = sreg_q | (DATA_WIDTH'(sd_s) << (CNT_W'(DATA_WIDTH - 1) - bit_cnt_q));
        end
    end

    always_comb begin
        sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], sck};
        ws_sync_d     = {ws_sync_q[SYNC_STAGES-2:0], ws};
        sd_sync_d     = {sd_sync_q[SYNC_STAGES-2:0], sd};
        sck_d_d       = sck_s;
        ws_d_d        = ws_d_q;
        state_d       = state_q;
        chan_d        = chan_q;
        bit_cnt_d     = bit_cnt_q;
        sreg_d        = sreg_q;
        data_left_d   = data_left_q;
        data_right_d  = data_right_q;
        left_valid_d  = 1'b0;
        right_valid_d = 1'b0;
        frame_valid_d = 1'b0;
        got_left_d    = got_left_q;
        locked_d      = locked_q;

        if (sck_rise) begin
            ws_d_d = ws_s;
            case (state_q)
                ST_IDLE: begin
                    if (ws_edge) begin
                        state_d   = ST_RECV;
                        chan_d    = ws_s;
                        bit_cnt_d = '0;
                        sreg_d    = '0;
                        locked_d  = 1'b1;
                    end
                end
                ST_RECV: begin
                    if (!ws_edge) begin
                        if (!cnt_full) begin
                            sreg_d    = sreg_ins;
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        // This edge carries the finishing slot's LSB (one-bit delay).
                        if (!chan_q) begin
                            data_left_d  = sreg_ins;
                            left_valid_d = 1'b1;
                            got_left_d   = 1'b1;
                        end else begin
                            data_right_d  = sreg_ins;
                            right_valid_d = 1'b1;
                            frame_valid_d = got_left_q;
                            got_left_d    = 1'b0;
                        end
                        chan_d    = ws_s;
                        bit_cnt_d = '0;
                        sreg_d    = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q    <= '0;
            ws_sync_q     <= '0;
            sd_sync_q     <= '0;
            sck_d_q       <= 1'b0;
            ws_d_q        <= 1'b0;
            state_q       <= ST_IDLE;
            chan_q        <= 1'b0;
            bit_cnt_q     <= '0;
            sreg_q        <= '0;
            data_left_q   <= '0;
            data_right_q  <= '0;
            left_valid_q  <= 1'b0;
            right_valid_q <= 1'b0;
            frame_valid_q <= 1'b0;
            got_left_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            sck_sync_q    <= sck_sync_d;
            ws_sync_q     <= ws_sync_d;
            sd_sync_q     <= sd_sync_d;
            sck_d_q       <= sck_d_d;
            ws_d_q        <= ws_d_d;
            state_q       <= state_d;
            chan_q        <= chan_d;
            bit_cnt_q     <= bit_cnt_d;
            sreg_q        <= sreg_d;
            data_left_q   <= data_left_d;
            data_right_q  <= data_right_d;
            left_valid_q  <= left_valid_d;
            right_valid_q <= right_valid_d;
            frame_valid_q <= frame_valid_d;
            got_left_q    <= got_left_d;
            locked_q      <= locked_d;
        end
    end

    assign data_left   = data_left_q;
    assign data_right  = data_right_q;
    assign left_valid  = left_valid_q;
    assign right_valid = right_valid_q;
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;

endmodule
